// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared types and default widths for the FFT result unloader
package fft_pkg;
  localparam int FFT_ADDR_WIDTH = 10;
  localparam int FFT_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } unload_state_t;
endpackage

// File: rtl/fft_unload_fifo.sv
// rtl/fft_unload_fifo.sv - two-entry FIFO holding result words with their index and last flag
module fft_unload_fifo #(
  parameter int DATA_WIDTH  = 32,
  parameter int INDEX_WIDTH = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [DATA_WIDTH-1:0]  push_data,
  input  logic [INDEX_WIDTH-1:0] push_index,
  input  logic                   push_last,
  input  logic                   pop,
  output logic                   valid,
  output logic [DATA_WIDTH-1:0]  data,
  output logic [INDEX_WIDTH-1:0] index,
  output logic                   last,
  output logic [1:0]             count
);
  logic [DATA_WIDTH-1:0]  data_mem  [2];
  logic [INDEX_WIDTH-1:0] index_mem [2];
  logic [1:0]             last_mem;
  logic                   wr_ptr;
  logic                   rd_ptr;
  logic                   do_pop;
  logic                   accept;

  assign do_pop = pop & (count != 2'd0);
  assign accept = push & ((count != 2'd2) | do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_mem[0]  <= '0;
      data_mem[1]  <= '0;
      index_mem[0] <= '0;
      index_mem[1] <= '0;
      last_mem     <= '0;
      wr_ptr       <= 1'b0;
      rd_ptr       <= 1'b0;
      count        <= 2'd0;
    end else begin
      if (accept) begin
        data_mem[wr_ptr]  <= push_data;
        index_mem[wr_ptr] <= push_index;
        last_mem[wr_ptr]  <= push_last;
        wr_ptr            <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, accept} - {1'b0, do_pop};
    end
  end

  // Head entry is never the write target while valid, so it holds still under stall.
  assign valid = (count != 2'd0);
  assign data  = data_mem[rd_ptr];
  assign index = index_mem[rd_ptr];
  assign last  = valid & last_mem[rd_ptr];
endmodule

// File: rtl/fft_result_unloader.sv
// rtl/fft_result_unloader.sv - streams the FFT result RAM out in natural or bit-reversed order
module fft_result_unloader
  import fft_pkg::*;
#(
  parameter int ADDR_WIDTH = FFT_ADDR_WIDTH,
  parameter int DATA_WIDTH = FFT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  bitrev_mode,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic [ADDR_WIDTH-1:0] out_index
);
  localparam logic [ADDR_WIDTH-1:0] LAST_SEQ = '1;

  unload_state_t         state;
  logic [ADDR_WIDTH-1:0] seq;
  logic                  mode;
  logic                  inflight;
  logic [ADDR_WIDTH-1:0] inflight_index;
  logic                  inflight_last;
  logic [1:0]            occupancy;
  logic                  pop;
  logic [2:0]            committed;

  // A read is only issued when the buffer is guaranteed a free slot when its data lands.
  assign pop       = out_valid & out_ready;
  assign committed = {1'b0, occupancy} + {2'b00, inflight};
  assign rd_en     = (state == RUN) && (committed < (3'd2 + {2'b00, pop}));

  for (genvar i = 0; i < ADDR_WIDTH; i++) begin : g_addr
    assign rd_addr[i] = mode ? seq[ADDR_WIDTH-1-i] : seq[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      seq            <= '0;
      mode           <= 1'b0;
      inflight       <= 1'b0;
      inflight_index <= '0;
      inflight_last  <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      inflight <= rd_en;
      if (rd_en) begin
        inflight_index <= seq;
        inflight_last  <= (seq == LAST_SEQ);
      end
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state <= RUN;
            mode  <= bitrev_mode;
            seq   <= '0;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          if (rd_en) begin
            if (seq == LAST_SEQ) state <= DRAIN;
            else seq <= seq + 1'b1;
          end
        end
        DRAIN: begin
          if (pop && out_last) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  fft_unload_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .INDEX_WIDTH(ADDR_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight),
    .push_data (rd_data),
    .push_index(inflight_index),
    .push_last (inflight_last),
    .pop       (pop),
    .valid     (out_valid),
    .data      (out_data),
    .index     (out_index),
    .last      (out_last),
    .count     (occupancy)
  );
endmodule

// File: tb/tb_fft_result_unloader.sv
// tb/tb_fft_result_unloader.sv - scoreboard bench for fft_result_unloader (8-word and 16-word instances)
module tb_fft_result_unloader;
  localparam int AW_A = 3;
  localparam int N_A  = 8;
  localparam int AW_B = 4;
  localparam int N_B  = 16;
  localparam int DW   = 16;

  typedef struct packed {
    logic [DW-1:0]   data;
    logic [AW_B-1:0] index;
    logic            last;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic            start_a = 1'b0, bitrev_a = 1'b0, ready_a = 1'b0;
  logic            busy_a, done_a, rd_en_a, valid_a, last_a;
  logic [AW_A-1:0] rd_addr_a, index_a;
  logic [DW-1:0]   rd_data_a, data_a;
  logic [DW-1:0]   mem_a [N_A];

  logic            start_b = 1'b0, bitrev_b = 1'b0, ready_b = 1'b0;
  logic            busy_b, done_b, rd_en_b, valid_b, last_b;
  logic [AW_B-1:0] rd_addr_b, index_b;
  logic [DW-1:0]   rd_data_b, data_b;
  logic [DW-1:0]   mem_b [N_B];

  fft_result_unloader #(.ADDR_WIDTH(AW_A), .DATA_WIDTH(DW)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .bitrev_mode(bitrev_a),
    .busy(busy_a), .done(done_a), .rd_en(rd_en_a), .rd_addr(rd_addr_a),
    .rd_data(rd_data_a), .out_valid(valid_a), .out_ready(ready_a),
    .out_data(data_a), .out_last(last_a), .out_index(index_a)
  );

  fft_result_unloader #(.ADDR_WIDTH(AW_B), .DATA_WIDTH(DW)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .bitrev_mode(bitrev_b),
    .busy(busy_b), .done(done_b), .rd_en(rd_en_b), .rd_addr(rd_addr_b),
    .rd_data(rd_data_b), .out_valid(valid_b), .out_ready(ready_b),
    .out_data(data_b), .out_last(last_b), .out_index(index_b)
  );

  // One-cycle-latency RAM models; poison data when no read was issued.
  always @(posedge clk) rd_data_a <= rd_en_a ? mem_a[rd_addr_a] : 16'hDEAD;
  always @(posedge clk) rd_data_b <= rd_en_b ? mem_b[rd_addr_b] : 16'hDEAD;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  exp_t exp_a_q[$];
  int   addr_a_q[$];
  int   rd_cnt_a, pop_cnt_a, done_cnt_a;
  int   first_valid_a, first_rd_a, last_rd_a, last_hs_a, done_cyc_a;
  logic held_valid_a;
  logic [DW+AW_A:0] held_a;

  function automatic int bitrev(input int v, input int w);
    int r;
    r = 0;
    for (int i = 0; i < w; i++) if (v[i]) r = r | (1 << (w - 1 - i));
    return r;
  endfunction

  task automatic reset_track_a();
    exp_a_q.delete();
    addr_a_q.delete();
    rd_cnt_a = 0; pop_cnt_a = 0; done_cnt_a = 0;
    first_valid_a = -1; first_rd_a = -1; last_rd_a = -1; last_hs_a = -1; done_cyc_a = -1;
    held_valid_a = 1'b0;
  endtask

  task automatic expect_frame_a(input logic mode);
    for (int i = 0; i < N_A; i++) begin
      int a;
      exp_t e;
      a = mode ? bitrev(i, AW_A) : i;
      addr_a_q.push_back(a);
      e.data = mem_a[a];
      e.index = AW_B'(i);
      e.last = (i == N_A - 1);
      exp_a_q.push_back(e);
    end
  endtask

  // One cycle on instance A: drive at the falling edge, observe 1 ns later.
  task automatic tick_a(input logic st, input logic md, input logic rdy);
    exp_t e;
    int a;
    logic pop_now;
    @(negedge clk);
    start_a = st; bitrev_a = md; ready_a = rdy;
    #1;
    cyc++;
    pop_now = valid_a && ready_a;
    if (held_valid_a && valid_a) begin
      checks++;
      if ({data_a, index_a, last_a} !== held_a) begin
        failures++;
        $display("FAIL stall_hold_a: got %h want %h", {data_a, index_a, last_a}, held_a);
      end
    end
    held_valid_a = valid_a && !ready_a;
    held_a = {data_a, index_a, last_a};
    if (rd_en_a) begin
      checks++;
      if (rd_cnt_a - pop_cnt_a - int'(pop_now) >= 2) begin
        failures++;
        $display("FAIL occupancy_a: outstanding %0d want <2", rd_cnt_a - pop_cnt_a - int'(pop_now));
      end
      checks++;
      if (addr_a_q.size() == 0) begin
        failures++;
        $display("FAIL rd_addr_a: unexpected read addr %0d want none", rd_addr_a);
      end else begin
        a = addr_a_q.pop_front();
        if (rd_addr_a !== AW_A'(a)) begin
          failures++;
          $display("FAIL rd_addr_a: got %0d want %0d", rd_addr_a, a);
        end
      end
      if (first_rd_a < 0) first_rd_a = cyc;
      last_rd_a = cyc;
      rd_cnt_a++;
    end
    if (pop_now) begin
      checks++;
      if (exp_a_q.size() == 0) begin
        failures++;
        $display("FAIL out_a: unexpected word %h idx %0d want none", data_a, index_a);
      end else begin
        e = exp_a_q.pop_front();
        if ({data_a, 1'b0, index_a, last_a} !== {e.data, e.index, e.last}) begin
          failures++;
          $display("FAIL out_a: got data %h idx %0d last %b want data %h idx %0d last %b",
                   data_a, index_a, last_a, e.data, e.index, e.last);
        end
      end
      if (first_valid_a < 0) first_valid_a = cyc;
      last_hs_a = cyc;
      pop_cnt_a++;
    end
    if (done_a) begin
      done_cnt_a++;
      done_cyc_a = cyc;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({busy_a, done_a, rd_en_a, valid_a, last_a, rd_addr_a, index_a, data_a} !== '0) begin
      failures++;
      $display("FAIL reset_a: got %b want all zero",
               {busy_a, done_a, rd_en_a, valid_a, last_a, rd_addr_a, index_a, data_a});
    end
    checks++;
    if ({busy_b, done_b, rd_en_b, valid_b, last_b, rd_addr_b, index_b, data_b} !== '0) begin
      failures++;
      $display("FAIL reset_b: got %b want all zero",
               {busy_b, done_b, rd_en_b, valid_b, last_b, rd_addr_b, index_b, data_b});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_frame_a(input logic mode, input int budget, output int s, output bit timed_out);
    int n;
    int d0;
    d0 = done_cnt_a;
    expect_frame_a(mode);
    tick_a(1'b1, mode, 1'b1);
    s = cyc;
    n = 0;
    while (done_cnt_a == d0 && n < budget) begin
      tick_a(1'b0, 1'b0, 1'b1);
      n++;
    end
    timed_out = (done_cnt_a == d0);
  endtask

  task automatic test_natural();
    int s;
    bit to;
    reset_track_a();
    run_frame_a(1'b0, 40, s, to);
    checks++;
    if (to) begin failures++; $display("FAIL natural_timeout: done not seen within 40 cycles"); end
    checks++;
    if (first_valid_a - s != 3) begin
      failures++; $display("FAIL natural_latency: got %0d want 3", first_valid_a - s);
    end
    checks++;
    if (first_rd_a != s + 1 || last_rd_a - first_rd_a != N_A - 1 || rd_cnt_a != N_A) begin
      failures++;
      $display("FAIL natural_rd_burst: first %0d last %0d count %0d want %0d %0d %0d",
               first_rd_a, last_rd_a, rd_cnt_a, s + 1, s + N_A, N_A);
    end
    checks++;
    if (done_cyc_a - last_hs_a != 1) begin
      failures++; $display("FAIL natural_done_delay: got %0d want 1", done_cyc_a - last_hs_a);
    end
    tick_a(1'b0, 1'b0, 1'b1);
    checks++;
    if ({busy_a, done_a} !== 2'b00 || exp_a_q.size() != 0 || addr_a_q.size() != 0) begin
      failures++;
      $display("FAIL natural_end: busy %b done %b left %0d/%0d want 0 0 0/0",
               busy_a, done_a, exp_a_q.size(), addr_a_q.size());
    end
  endtask

  task automatic test_bitrev();
    int s;
    bit to;
    reset_track_a();
    run_frame_a(1'b1, 40, s, to);
    checks++;
    if (to) begin failures++; $display("FAIL bitrev_timeout: done not seen within 40 cycles"); end
    checks++;
    if (pop_cnt_a != N_A || exp_a_q.size() != 0 || addr_a_q.size() != 0) begin
      failures++;
      $display("FAIL bitrev_count: got %0d words left %0d/%0d want %0d 0/0",
               pop_cnt_a, exp_a_q.size(), addr_a_q.size(), N_A);
    end
    checks++;
    if (done_cyc_a - last_hs_a != 1) begin
      failures++; $display("FAIL bitrev_done_delay: got %0d want 1", done_cyc_a - last_hs_a);
    end
  endtask

  task automatic test_ignore_start();
    reset_track_a();
    expect_frame_a(1'b0);
    tick_a(1'b1, 1'b0, 1'b1);
    for (int j = 1; j <= 20; j++) begin
      if (j == 2 || j == 9 || j == 11) tick_a(1'b1, 1'b1, 1'b1);
      else tick_a(1'b0, 1'b0, 1'b1);
    end
    checks++;
    if (pop_cnt_a != N_A || done_cnt_a != 1 || rd_cnt_a != N_A) begin
      failures++;
      $display("FAIL ignore_start: words %0d done %0d reads %0d want %0d 1 %0d",
               pop_cnt_a, done_cnt_a, rd_cnt_a, N_A, N_A);
    end
    checks++;
    if (busy_a !== 1'b0 || exp_a_q.size() != 0) begin
      failures++;
      $display("FAIL ignore_start_idle: busy %b left %0d want 0 0", busy_a, exp_a_q.size());
    end
  endtask

  task automatic test_reset_midframe();
    int s;
    int seen;
    bit found;
    bit to;
    reset_track_a();
    expect_frame_a(1'b0);
    tick_a(1'b1, 1'b0, 1'b1);
    found = 1'b0;
    for (int j = 0; j < 20 && !found; j++) begin
      tick_a(1'b0, 1'b0, 1'b1);
      if (valid_a && index_a == 3'd3) found = 1'b1;
    end
    checks++;
    if (!found) begin failures++; $display("FAIL midframe_reach: index 3 not seen within 20 cycles"); end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy_a, done_a, rd_en_a, valid_a, last_a, rd_addr_a, index_a, data_a} !== '0) begin
      failures++;
      $display("FAIL midframe_async_reset: got %b want all zero",
               {busy_a, done_a, rd_en_a, valid_a, last_a, rd_addr_a, index_a, data_a});
    end
    reset_track_a();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int j = 0; j < 6; j++) begin
      tick_a(1'b0, 1'b0, 1'b1);
      if (valid_a || rd_en_a || busy_a) seen++;
    end
    checks++;
    if (seen != 0) begin failures++; $display("FAIL midframe_quiet: active cycles %0d want 0", seen); end
    run_frame_a(1'b0, 40, s, to);
    checks++;
    if (to || pop_cnt_a != N_A || exp_a_q.size() != 0) begin
      failures++;
      $display("FAIL midframe_restart: timeout %b words %0d left %0d want 0 %0d 0",
               to, pop_cnt_a, exp_a_q.size(), N_A);
    end
  endtask

  task automatic test_back_to_back();
    int s;
    bit to;
    reset_track_a();
    run_frame_a(1'b0, 40, s, to);
    checks++;
    if (to) begin failures++; $display("FAIL b2b_first_timeout: done not seen within 40 cycles"); end
    first_valid_a = -1;
    run_frame_a(1'b1, 40, s, to);
    checks++;
    if (to) begin failures++; $display("FAIL b2b_second_timeout: done not seen within 40 cycles"); end
    checks++;
    if (first_valid_a - s != 3) begin
      failures++; $display("FAIL b2b_latency: got %0d want 3", first_valid_a - s);
    end
    checks++;
    if (pop_cnt_a != 2 * N_A || done_cnt_a != 2 || exp_a_q.size() != 0) begin
      failures++;
      $display("FAIL b2b_count: words %0d done %0d left %0d want %0d 2 0",
               pop_cnt_a, done_cnt_a, exp_a_q.size(), 2 * N_A);
    end
  endtask

  task automatic test_backpressure();
    exp_t q[$];
    exp_t e;
    int rd_cnt, pop_cnt, frames, done_cnt, t, wait_n, a;
    logic mode, pop_now, held_v;
    logic [DW+AW_B:0] held;
    rd_cnt = 0; pop_cnt = 0; frames = 0; done_cnt = 0; t = 0; held_v = 1'b0; held = '0;
    while (t < 1000) begin
      mode = 1'($urandom_range(0, 1));
      for (int i = 0; i < N_B; i++) begin
        a = mode ? bitrev(i, AW_B) : i;
        e.data = mem_b[a];
        e.index = AW_B'(i);
        e.last = (i == N_B - 1);
        q.push_back(e);
      end
      @(negedge clk);
      start_b = 1'b1; bitrev_b = mode; ready_b = 1'($urandom_range(0, 1));
      #1;
      t++;
      frames++;
      wait_n = 0;
      while (done_cnt < frames && wait_n < 200) begin
        @(negedge clk);
        start_b = 1'b0; ready_b = 1'($urandom_range(0, 1));
        #1;
        t++; wait_n++;
        pop_now = valid_b && ready_b;
        if (held_v && valid_b) begin
          checks++;
          if ({data_b, index_b, last_b} !== held) begin
            failures++;
            $display("FAIL stall_hold_b: got %h want %h", {data_b, index_b, last_b}, held);
          end
        end
        held_v = valid_b && !ready_b;
        held = {data_b, index_b, last_b};
        if (rd_en_b) begin
          checks++;
          if (rd_cnt - pop_cnt - int'(pop_now) >= 2) begin
            failures++;
            $display("FAIL occupancy_b: outstanding %0d want <2", rd_cnt - pop_cnt - int'(pop_now));
          end
          rd_cnt++;
        end
        if (pop_now) begin
          checks++;
          if (q.size() == 0) begin
            failures++;
            $display("FAIL out_b: unexpected word %h idx %0d want none", data_b, index_b);
          end else begin
            e = q.pop_front();
            if ({data_b, index_b, last_b} !== {e.data, e.index, e.last}) begin
              failures++;
              $display("FAIL out_b: got data %h idx %0d last %b want data %h idx %0d last %b",
                       data_b, index_b, last_b, e.data, e.index, e.last);
            end
          end
          pop_cnt++;
        end
        if (done_b) done_cnt++;
      end
      checks++;
      if (done_cnt < frames) begin
        failures++; $display("FAIL backpressure_timeout: frame %0d not done within 200 cycles", frames);
      end
    end
    checks++;
    if (q.size() != 0 || pop_cnt != frames * N_B || done_cnt != frames) begin
      failures++;
      $display("FAIL backpressure_total: words %0d done %0d left %0d want %0d %0d 0",
               pop_cnt, done_cnt, q.size(), frames * N_B, frames);
    end
  endtask

  initial begin
    for (int i = 0; i < N_A; i++) mem_a[i] = {8'($urandom_range(0, 255)), 8'(i)};
    for (int i = 0; i < N_B; i++) mem_b[i] = {8'($urandom_range(0, 255)), 8'(i + 8'h40)};
    test_reset();
    test_natural();
    test_bitrev();
    test_ignore_start();
    test_reset_midframe();
    test_back_to_back();
    test_backpressure();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
